// File: rtl/spmm_pkg.sv
// Shared CSR/SpMM definitions: array geometry, section tags and the element
// selector used by every block that walks a 512-bit CSR array.
package spmm_pkg;

  localparam int unsigned ARR_LEN = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ARR_W   = ARR_LEN * WORD_W;
  localparam int unsigned IDX_W   = $clog2(ARR_LEN);

  typedef enum logic [1:0] {
    SECT_RP = 2'd0,
    SECT_NV = 2'd1,
    SECT_CI = 2'd2
  } sect_e;

  // Element 0 sits in the most significant word of the flat vector
  typedef logic [0:ARR_LEN-1][WORD_W-1:0] arr_t;

  function automatic logic [WORD_W-1:0] get_word(arr_t arr, logic [IDX_W-1:0] idx);
    return arr[idx];
  endfunction

endpackage

// File: rtl/csr_c_streamer_if.sv
// Outbound 32-bit valid/ready word stream carrying a CSR frame with section tags.
interface csr_c_streamer_if;
  import spmm_pkg::*;

  logic [WORD_W-1:0] m_data_o;
  logic [1:0]        m_sect_o;
  logic              m_last_o;
  logic              m_valid_o;
  logic              m_ready_i;

  modport master (
    output m_data_o,
    output m_sect_o,
    output m_last_o,
    output m_valid_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o,
    input  m_sect_o,
    input  m_last_o,
    input  m_valid_o,
    output m_ready_i
  );

endinterface

// File: rtl/csr_c_streamer.sv
// Captures the CSR result matrix C on a completion edge and streams it out as
// RP, NV, CI sections over a registered valid/ready word interface.
module csr_c_streamer
  import spmm_pkg::*;
#(
  parameter int unsigned N_ROWS = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ARR_W-1:0]  nvc_i,
  input  logic [ARR_W-1:0]  cic_i,
  input  logic [ARR_W-1:0]  rpc_i,
  input  logic              start_i,
  csr_c_streamer_if.master  m,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RP,
    ST_NV,
    ST_CI,
    ST_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        nnz_q, nnz_d;
  arr_t              nvc_q, nvc_d, cic_q, cic_d, rpc_q, rpc_d;
  logic              start_prev_q;
  logic [WORD_W-1:0] data_q, data_d;
  sect_e             sect_q, sect_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs;
  logic              start_edge;
  logic [WORD_W-1:0] rp_tail;
  logic [4:0]        nnz_cap;
  logic [4:0]        idx_inc;
  logic [4:0]        nnz_last;

  assign hs         = valid_q && m.m_ready_i;
  assign start_edge = start_i && !start_prev_q;
  assign rp_tail    = get_word(arr_t'(rpc_i), IDX_W'(N_ROWS));
  assign nnz_cap    = (rp_tail > WORD_W'(ARR_LEN)) ? 5'(ARR_LEN) : rp_tail[4:0];
  assign idx_inc    = idx_q + 5'd1;
  assign nnz_last   = nnz_q - 5'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      nnz_q        <= '0;
      nvc_q        <= '0;
      cic_q        <= '0;
      rpc_q        <= '0;
      start_prev_q <= 1'b1;
      data_q       <= '0;
      sect_q       <= SECT_RP;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      nnz_q        <= nnz_d;
      nvc_q        <= nvc_d;
      cic_q        <= cic_d;
      rpc_q        <= rpc_d;
      start_prev_q <= start_i;
      data_q       <= data_d;
      sect_q       <= sect_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next word is loaded on the handshake edge so the stream has no bubbles
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nnz_d   = nnz_q;
    nvc_d   = nvc_q;
    cic_d   = cic_q;
    rpc_d   = rpc_q;
    data_d  = data_q;
    sect_d  = sect_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          rpc_d   = arr_t'(rpc_i);
          nvc_d   = arr_t'(nvc_i);
          cic_d   = arr_t'(cic_i);
          nnz_d   = nnz_cap;
          state_d = ST_RP;
          idx_d   = '0;
          data_d  = get_word(arr_t'(rpc_i), '0);
          sect_d  = SECT_RP;
          last_d  = (N_ROWS == 0) && (nnz_cap == 5'd0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RP: begin
        if (hs) begin
          if (idx_q == 5'(N_ROWS)) begin
            if (nnz_q == 5'd0) begin
              state_d = ST_FIN;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              data_d  = '0;
              sect_d  = SECT_RP;
            end else begin
              state_d = ST_NV;
              idx_d   = '0;
              data_d  = get_word(nvc_q, '0);
              sect_d  = SECT_NV;
              last_d  = 1'b0;
            end
          end else begin
            idx_d  = idx_inc;
            data_d = get_word(rpc_q, idx_inc[IDX_W-1:0]);
            last_d = (idx_inc == 5'(N_ROWS)) && (nnz_q == 5'd0);
          end
        end
      end
      ST_NV: begin
        if (hs) begin
          if (idx_q == nnz_last) begin
            state_d = ST_CI;
            idx_d   = '0;
            data_d  = get_word(cic_q, '0);
            sect_d  = SECT_CI;
            last_d  = (nnz_q == 5'd1);
          end else begin
            idx_d  = idx_inc;
            data_d = get_word(nvc_q, idx_inc[IDX_W-1:0]);
          end
        end
      end
      ST_CI: begin
        if (hs) begin
          if (idx_q == nnz_last) begin
            state_d = ST_FIN;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = '0;
            sect_d  = SECT_RP;
          end else begin
            idx_d  = idx_inc;
            data_d = get_word(cic_q, idx_inc[IDX_W-1:0]);
            last_d = (idx_inc == nnz_last);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m.m_data_o  = data_q;
  assign m.m_sect_o  = sect_q;
  assign m.m_last_o  = last_q;
  assign m.m_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
